bitblade_ctrl: RTL and testbench

BITBLADE_CTRL -- requirements
Module: bitblade_ctrl

---
 rtl/bitblade_ctrl_if.sv | 34 +++
 rtl/bitblade_ctrl.sv | 126 ++++++++++++
 tb/tb_bitblade_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bitblade_ctrl_if.sv
// CPU custom-instruction port bundle for the Bitblade MAC controller.
// The CPU drives the command side and consumes the response side.
interface bitblade_ctrl_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [9:0]  cmd_payload_function_id;
  logic [31:0] cmd_payload_inputs_0;
  logic [31:0] cmd_payload_inputs_1;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_payload_outputs_0;

  modport master (
    output cmd_valid,
    input  cmd_ready,
    output cmd_payload_function_id,
    output cmd_payload_inputs_0,
    output cmd_payload_inputs_1,
    input  rsp_valid,
    output rsp_ready,
    input  rsp_payload_outputs_0
  );

  modport slave (
    input  cmd_valid,
    output cmd_ready,
    input  cmd_payload_function_id,
    input  cmd_payload_inputs_0,
    input  cmd_payload_inputs_1,
    output rsp_valid,
    input  rsp_ready,
    output rsp_payload_outputs_0
  );
endinterface

// File: rtl/bitblade_ctrl.sv
// Bitblade byte dot-product unit plus a MAC controller with a 32-bit
// wrapping accumulator and a saturating MAC counter.
module bitblade_dot (
  input  logic [63:0] in_a,
  input  logic [63:0] in_b,
  output logic [17:0] out_c
);
  logic [15:0] p;

  always_comb begin
    out_c = '0;
    p     = '0;
    for (int i = 0; i < 8; i++) begin
      p     = in_a[8*i +: 8] * in_b[8*i +: 8];
      out_c = out_c + {2'b00, p};
    end
  end
endmodule

module bitblade_ctrl #(
  parameter int CNT_W = 16
) (
  input logic             clk,
  input logic             reset,
  bitblade_ctrl_if.slave  bus
);
  typedef enum logic [2:0] {
    IDLE, OPR, PROD, ACC, RESP
  } state_t;

  state_t           state_q, state_d;
  logic [31:0]      opa_q, opa_d;
  logic [31:0]      opb_q, opb_d;
  logic [17:0]      prod_q, prod_d;
  logic [31:0]      acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      rsp_q, rsp_d;
  logic [17:0]      out_c;
  logic [2:0]       op;

  assign op = bus.cmd_payload_function_id[2:0];

  // The dot unit only ever sees the OPR registers, never the live bus.
  bitblade_dot u_dot (
    .in_a  ({32'h0, opa_q}),
    .in_b  ({32'h0, opb_q}),
    .out_c (out_c)
  );

  assign bus.cmd_ready = (state_q == IDLE) && !reset;
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_payload_outputs_0 = rsp_q;

  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    prod_d  = prod_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    rsp_d   = rsp_q;
    unique case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          state_d = RESP;
          case (op)
            3'd0: begin
              acc_d = '0;
              cnt_d = '0;
              rsp_d = '0;
            end
            3'd1: begin
              opa_d   = bus.cmd_payload_inputs_0;
              opb_d   = bus.cmd_payload_inputs_1;
              state_d = OPR;
            end
            3'd2: rsp_d = acc_q;
            3'd3: rsp_d = 32'(cnt_q);
            3'd4: begin
              acc_d = bus.cmd_payload_inputs_0;
              rsp_d = bus.cmd_payload_inputs_0;
            end
            default: rsp_d = '0;
          endcase
        end
      end
      OPR: begin
        prod_d  = out_c;
        state_d = PROD;
      end
      PROD: begin
        acc_d   = acc_q + {14'h0, prod_q};
        cnt_d   = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
        state_d = ACC;
      end
      ACC: begin
        rsp_d   = acc_q;
        state_d = RESP;
      end
      RESP: begin
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      prod_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      rsp_q   <= '0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      prod_q  <= prod_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      rsp_q   <= rsp_d;
    end
  end
endmodule

// File: tb/tb_bitblade_ctrl.sv
// Directed bench for bitblade_ctrl: latency, datapath, wrap,
// backpressure, reset abort and counter saturation.
module tb_bitblade_ctrl;
  logic clk;
  logic reset;
  int   errors;
  int   checks;
  int   overlap;

  bitblade_ctrl_if bus ();

  bitblade_ctrl #(.CNT_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk)
    if (bus.cmd_ready && bus.rsp_valid) overlap++;

  localparam logic [2:0] CLR = 3'd0;
  localparam logic [2:0] MAC = 3'd1;
  localparam logic [2:0] RD  = 3'd2;
  localparam logic [2:0] CNT = 3'd3;
  localparam logic [2:0] LD  = 3'd4;

  // Issue one command with rsp_ready high; called and returns #1 after an edge.
  task automatic do_cmd(input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, output logic [31:0] rsp,
                        output int lat);
    int n;
    bus.cmd_valid = 1'b1;
    bus.cmd_payload_function_id = {7'h5A, op};
    bus.cmd_payload_inputs_0 = a;
    bus.cmd_payload_inputs_1 = b;
    bus.rsp_ready = 1'b1;
    n = 0;
    while (!bus.cmd_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    if (!bus.cmd_ready) begin
      checks++; errors++;
      $display("FAIL cmd_ready_timeout op=%0d got=0 want=1", op);
    end
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    bus.cmd_payload_inputs_0 = $urandom;
    bus.cmd_payload_inputs_1 = $urandom;
    lat = 1;
    while (!bus.rsp_valid && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    if (!bus.rsp_valid) begin
      checks++; errors++;
      $display("FAIL rsp_valid_timeout op=%0d got=0 want=1", op);
    end
    rsp = bus.rsp_payload_outputs_0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    bus.cmd_payload_function_id = '0;
    bus.cmd_payload_inputs_0 = '0;
    bus.cmd_payload_inputs_1 = '0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_cmd_ready got=%b want=0", bus.cmd_ready);
    end
    checks++;
    if (bus.rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_rsp_valid got=%b want=0", bus.rsp_valid);
    end
    checks++;
    if (bus.rsp_payload_outputs_0 !== 32'h0) begin
      errors++;
      $display("FAIL reset_payload got=%h want=0", bus.rsp_payload_outputs_0);
    end
    reset = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (bus.cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready got=%b want=1", bus.cmd_ready);
    end
  endtask

  task automatic test_basic_mac;
    logic [31:0] r;
    int l;
    do_cmd(CLR, 32'h0, 32'h0, r, l);
    checks++;
    if (r !== 32'h0 || l !== 1) begin
      errors++;
      $display("FAIL clear_rsp got=%h/%0d want=0/1", r, l);
    end
    do_cmd(MAC, 32'h01020304, 32'h05060708, r, l);
    checks++;
    if (r !== 32'h46) begin
      errors++;
      $display("FAIL basic_mac got=%h want=00000046", r);
    end
    checks++;
    if (l !== 4) begin
      errors++;
      $display("FAIL mac_latency got=%0d want=4", l);
    end
  endtask

  task automatic test_max;
    logic [31:0] r;
    int l;
    do_cmd(CLR, 32'h0, 32'h0, r, l);
    do_cmd(MAC, 32'hFFFFFFFF, 32'hFFFFFFFF, r, l);
    checks++;
    if (r !== 32'h0003F804) begin
      errors++;
      $display("FAIL max_mac1 got=%h want=0003f804", r);
    end
    do_cmd(MAC, 32'hFFFFFFFF, 32'hFFFFFFFF, r, l);
    checks++;
    if (r !== 32'h0007F008) begin
      errors++;
      $display("FAIL max_mac2 got=%h want=0007f008", r);
    end
    do_cmd(CNT, 32'h0, 32'h0, r, l);
    checks++;
    if (r !== 32'h2 || l !== 1) begin
      errors++;
      $display("FAIL max_count got=%h/%0d want=2/1", r, l);
    end
  endtask

  task automatic test_wrap;
    logic [31:0] r;
    int l;
    do_cmd(LD, 32'hFFFFFFF0, 32'h12345678, r, l);
    checks++;
    if (r !== 32'hFFFFFFF0) begin
      errors++;
      $display("FAIL load_rsp got=%h want=fffffff0", r);
    end
    do_cmd(MAC, 32'h00000001, 32'h00000020, r, l);
    checks++;
    if (r !== 32'h10) begin
      errors++;
      $display("FAIL wrap_mac got=%h want=00000010", r);
    end
    do_cmd(RD, 32'hDEADBEEF, 32'h0, r, l);
    checks++;
    if (r !== 32'h10) begin
      errors++;
      $display("FAIL wrap_read got=%h want=00000010", r);
    end
  endtask

  task automatic test_unused_ops;
    logic [31:0] r;
    int l;
    for (int op = 5; op < 8; op++) begin
      do_cmd(3'(op), 32'hCAFEF00D, 32'h11111111, r, l);
      checks++;
      if (r !== 32'h0) begin
        errors++;
        $display("FAIL unused_op%0d got=%h want=0", op, r);
      end
    end
    do_cmd(RD, 32'h0, 32'h0, r, l);
    checks++;
    if (r !== 32'h10) begin
      errors++;
      $display("FAIL unused_keep_acc got=%h want=00000010", r);
    end
  endtask

  task automatic test_backpressure;
    logic [31:0] r;
    int l;
    int bad;
    do_cmd(CLR, 32'h0, 32'h0, r, l);
    bus.rsp_ready = 1'b0;
    bus.cmd_valid = 1'b1;
    bus.cmd_payload_function_id = {7'h0, MAC};
    bus.cmd_payload_inputs_0 = 32'h01010101;
    bus.cmd_payload_inputs_1 = 32'h02020202;
    @(posedge clk); #1;
    bad = 0;
    for (int i = 0; i < 13; i++) begin
      bus.cmd_payload_function_id = {7'h0, (i[0] ? CLR : MAC)};
      bus.cmd_payload_inputs_0 = 32'hFFFFFFFF - i;
      bus.cmd_payload_inputs_1 = 32'hFFFFFFFF;
      if (bus.cmd_ready !== 1'b0) bad++;
      if (i >= 3) begin
        if (bus.rsp_valid !== 1'b1) bad++;
        if (bus.rsp_payload_outputs_0 !== 32'h8) bad++;
      end
      @(posedge clk); #1;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL backpressure_hold bad=%0d want=0 payload=%h",
               bad, bus.rsp_payload_outputs_0);
    end
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus.rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL backpressure_single_rsp got=%b want=0", bus.rsp_valid);
    end
    do_cmd(RD, 32'h0, 32'h0, r, l);
    checks++;
    if (r !== 32'h8) begin
      errors++;
      $display("FAIL backpressure_read got=%h want=00000008", r);
    end
    do_cmd(CNT, 32'h0, 32'h0, r, l);
    checks++;
    if (r !== 32'h1) begin
      errors++;
      $display("FAIL backpressure_count got=%h want=1", r);
    end
  endtask

  task automatic test_reset_mid;
    logic [31:0] r;
    int l;
    int seen;
    do_cmd(LD, 32'h00000005, 32'h0, r, l);
    bus.cmd_valid = 1'b1;
    bus.cmd_payload_function_id = {7'h0, MAC};
    bus.cmd_payload_inputs_0 = 32'h01010101;
    bus.cmd_payload_inputs_1 = 32'h01010101;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    seen = 0;
    repeat (2) begin
      @(posedge clk); #1;
      if (bus.rsp_valid) seen++;
    end
    reset = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (bus.rsp_valid) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL reset_mid_no_rsp got=%0d want=0", seen);
    end
    do_cmd(RD, 32'h0, 32'h0, r, l);
    checks++;
    if (r !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid_read got=%h want=0", r);
    end
    do_cmd(CNT, 32'h0, 32'h0, r, l);
    checks++;
    if (r !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid_count got=%h want=0", r);
    end
  endtask

  task automatic test_saturation;
    logic [31:0] r;
    int l;
    do_cmd(CLR, 32'h0, 32'h0, r, l);
    for (int i = 0; i < 300; i++) do_cmd(MAC, 32'h0, 32'h0, r, l);
    do_cmd(CNT, 32'h0, 32'h0, r, l);
    checks++;
    if (r !== 32'hFF) begin
      errors++;
      $display("FAIL sat_count got=%h want=000000ff", r);
    end
    do_cmd(RD, 32'h0, 32'h0, r, l);
    checks++;
    if (r !== 32'h0) begin
      errors++;
      $display("FAIL sat_read got=%h want=0", r);
    end
  endtask

  initial begin
    errors  = 0;
    checks  = 0;
    overlap = 0;
    reset   = 1'b0;
    test_reset;
    test_basic_mac;
    test_max;
    test_wrap;
    test_unused_ops;
    test_backpressure;
    test_reset_mid;
    test_saturation;
    checks++;
    if (overlap != 0) begin
      errors++;
      $display("FAIL ready_valid_overlap got=%0d want=0", overlap);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
